// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes, FSM states,
// the packed control-strobe vector and the memory-operation classifier.
package control_sequencer_pkg;

    localparam int OPCODE_WIDTH = 4;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    // Opcode map; 4'd11..4'd15 are unassigned and reported as illegal.
    localparam opcode_t OPER_READ_REGS          = opcode_t'(0);
    localparam opcode_t OPER_WRITE_REG          = opcode_t'(1);
    localparam opcode_t OPER_ENABLE_ALU_AND_RUN = opcode_t'(2);
    localparam opcode_t OPER_RESET              = opcode_t'(3);
    localparam opcode_t OPER_SET_PC             = opcode_t'(4);
    localparam opcode_t OPER_READ_MEM           = opcode_t'(5);
    localparam opcode_t OPER_READ_INST          = opcode_t'(6);
    localparam opcode_t OPER_WRITE_MEM          = opcode_t'(7);
    localparam opcode_t OPER_PUSH_TO_STACK      = opcode_t'(8);
    localparam opcode_t OPER_POP_FROM_STACK     = opcode_t'(9);
    localparam opcode_t OPER_HALT               = opcode_t'(10);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic en_reg_file;
        logic reg_file_rst;
        logic inc;
        logic dec;
        logic en_write;
        logic enable_alu;
        logic sram_wr_n;
        logic sram_cs_n;
        logic sram_oe_n;
    } ctrl_t;

    localparam ctrl_t IDLE_VECTOR = ctrl_t'(9'b000000_111);

    function automatic logic is_mem_op(input opcode_t op);
        logic mem;
        case (op)
            OPER_READ_MEM, OPER_READ_INST, OPER_WRITE_MEM,
            OPER_PUSH_TO_STACK, OPER_POP_FROM_STACK: mem = 1'b1;
            default:                                 mem = 1'b0;
        endcase
        return mem;
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Pure combinational map from a latched opcode and the final-cycle flag to the
// nine control strobes, plus an illegal-opcode indication.
module control_decode
    import control_sequencer_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] operation,
    input  logic                    final_cycle,
    output logic [8:0]              ctrl_bits,
    output logic                    illegal
);

    ctrl_t ctrl;

    always_comb begin
        ctrl    = IDLE_VECTOR;
        illegal = 1'b0;
        case (opcode_t'(operation))
            OPER_READ_REGS: begin
                ctrl.en_reg_file = 1'b1;
            end
            OPER_WRITE_REG: begin
                ctrl.en_reg_file = 1'b1;
                ctrl.en_write    = 1'b1;
            end
            OPER_ENABLE_ALU_AND_RUN: begin
                ctrl.enable_alu = 1'b1;
            end
            OPER_RESET: begin
                ctrl.en_reg_file  = 1'b1;
                ctrl.reg_file_rst = 1'b1;
            end
            OPER_SET_PC, OPER_HALT: begin
                ctrl = IDLE_VECTOR;
            end
            OPER_READ_MEM, OPER_READ_INST: begin
                ctrl.sram_cs_n = 1'b0;
                ctrl.sram_oe_n = 1'b0;
            end
            OPER_WRITE_MEM: begin
                ctrl.sram_cs_n = 1'b0;
                ctrl.sram_wr_n = 1'b0;
            end
            // Stack pointer moves only once the SRAM access is complete.
            OPER_PUSH_TO_STACK: begin
                ctrl.sram_cs_n = 1'b0;
                ctrl.sram_wr_n = 1'b0;
                if (final_cycle) begin
                    ctrl.en_reg_file = 1'b1;
                    ctrl.en_write    = 1'b1;
                    ctrl.inc         = 1'b1;
                end
            end
            OPER_POP_FROM_STACK: begin
                ctrl.sram_cs_n = 1'b0;
                ctrl.sram_oe_n = 1'b0;
                if (final_cycle) begin
                    ctrl.en_reg_file = 1'b1;
                    ctrl.en_write    = 1'b1;
                    ctrl.dec         = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign ctrl_bits = ctrl;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: accepts one opcode per valid/ready handshake and
// drives register-file, ALU and SRAM strobes for as many cycles as the op needs.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPERATION_CODE_LENGTH = OPCODE_WIDTH,
    parameter int SRAM_WAIT_CYCLES      = 1,
    parameter int WAIT_CNT_WIDTH        = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [OPERATION_CODE_LENGTH-1:0] operation,
    input  logic                             op_valid,
    output logic                             op_ready,
    output logic                             done,
    output logic                             illegal_op,
    output logic                             halted,
    output logic                             w_RegFile_en_reg_file,
    output logic                             w_RegFile_rst,
    output logic                             w_RegFile_inc,
    output logic                             w_RegFile_dec,
    output logic                             w_RegFile_en_write,
    output logic                             w_ALU_enable_alu,
    output logic                             w_SRAM_wr_n,
    output logic                             w_SRAM_cs_n,
    output logic                             w_SRAM_oe_n
);

    state_t                   state;
    state_t                   state_next;
    opcode_t                  op_q;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic                     accept;
    logic                     final_cycle;
    logic [8:0]               dec_bits;
    logic                     dec_illegal;
    ctrl_t                    ctrl;

    assign accept      = (state == ST_IDLE) && op_valid;
    assign final_cycle = (wait_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Non-memory ops load zero so every op ends on the same counter==0 condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            wait_cnt <= '0;
        end else if (accept) begin
            op_q     <= opcode_t'(operation);
            wait_cnt <= is_mem_op(opcode_t'(operation)) ?
                        WAIT_CNT_WIDTH'(SRAM_WAIT_CYCLES) : '0;
        end else if (state == ST_EXEC && !final_cycle) begin
            wait_cnt <= wait_cnt - WAIT_CNT_WIDTH'(1);
        end
    end

    control_decode u_decode (
        .operation   (op_q),
        .final_cycle (final_cycle),
        .ctrl_bits   (dec_bits),
        .illegal     (dec_illegal)
    );

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        done       = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;
        ctrl       = IDLE_VECTOR;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ctrl       = ctrl_t'(dec_bits);
                done       = final_cycle;
                illegal_op = dec_illegal && final_cycle;
                if (final_cycle) begin
                    state_next = (op_q == OPER_HALT) ? ST_HALTED : ST_IDLE;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign w_RegFile_en_reg_file = ctrl.en_reg_file;
    assign w_RegFile_rst         = ctrl.reg_file_rst;
    assign w_RegFile_inc         = ctrl.inc;
    assign w_RegFile_dec         = ctrl.dec;
    assign w_RegFile_en_write    = ctrl.en_write;
    assign w_ALU_enable_alu      = ctrl.enable_alu;
    assign w_SRAM_wr_n           = ctrl.sram_wr_n;
    assign w_SRAM_cs_n           = ctrl.sram_cs_n;
    assign w_SRAM_oe_n           = ctrl.sram_oe_n;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle output vectors are
// queued as stimulus is driven and compared on the following falling edge.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam int W = 2;
    localparam logic [8:0]  IDLE_S     = 9'b000000_111;
    localparam logic [12:0] READY_IDLE = {4'b1000, IDLE_S};
    localparam logic [12:0] HALTED_VEC = {4'b0001, IDLE_S};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [OPCODE_WIDTH-1:0] operation = '0;
    logic op_valid = 1'b0;
    logic op_ready, done, illegal_op, halted;
    logic rf_en, rf_rst, rf_inc, rf_dec, rf_we, alu_en, wr_n, cs_n, oe_n;

    logic [OPCODE_WIDTH-1:0] w0_operation = '0;
    logic w0_valid = 1'b0;
    logic w0_ready, w0_done, w0_illegal, w0_halted;
    logic w0_rf_en, w0_rf_rst, w0_inc, w0_dec, w0_we, w0_alu, w0_wr_n, w0_cs_n, w0_oe_n;

    int n_checks = 0;
    int n_fail   = 0;

    string       tag_q[$];
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    control_sequencer #(
        .OPERATION_CODE_LENGTH (OPCODE_WIDTH),
        .SRAM_WAIT_CYCLES      (W),
        .WAIT_CNT_WIDTH        (4)
    ) dut (
        .clk (clk), .rst (rst), .operation (operation), .op_valid (op_valid),
        .op_ready (op_ready), .done (done), .illegal_op (illegal_op), .halted (halted),
        .w_RegFile_en_reg_file (rf_en), .w_RegFile_rst (rf_rst),
        .w_RegFile_inc (rf_inc), .w_RegFile_dec (rf_dec),
        .w_RegFile_en_write (rf_we), .w_ALU_enable_alu (alu_en),
        .w_SRAM_wr_n (wr_n), .w_SRAM_cs_n (cs_n), .w_SRAM_oe_n (oe_n)
    );

    control_sequencer #(
        .OPERATION_CODE_LENGTH (OPCODE_WIDTH),
        .SRAM_WAIT_CYCLES      (0),
        .WAIT_CNT_WIDTH        (4)
    ) dut_w0 (
        .clk (clk), .rst (rst), .operation (w0_operation), .op_valid (w0_valid),
        .op_ready (w0_ready), .done (w0_done), .illegal_op (w0_illegal), .halted (w0_halted),
        .w_RegFile_en_reg_file (w0_rf_en), .w_RegFile_rst (w0_rf_rst),
        .w_RegFile_inc (w0_inc), .w_RegFile_dec (w0_dec),
        .w_RegFile_en_write (w0_we), .w_ALU_enable_alu (w0_alu),
        .w_SRAM_wr_n (w0_wr_n), .w_SRAM_cs_n (w0_cs_n), .w_SRAM_oe_n (w0_oe_n)
    );

    wire [12:0] act_vec = {op_ready, done, illegal_op, halted,
                           rf_en, rf_rst, rf_inc, rf_dec, rf_we, alu_en, wr_n, cs_n, oe_n};
    wire [12:0] w0_vec  = {w0_ready, w0_done, w0_illegal, w0_halted,
                           w0_rf_en, w0_rf_rst, w0_inc, w0_dec, w0_we, w0_alu,
                           w0_wr_n, w0_cs_n, w0_oe_n};

    task automatic checkOutput(input string tag, input logic [12:0] actual,
                               input logic [12:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b (rdy,done,ill,halt,en,rst,inc,dec,we,alu,wr_n,cs_n,oe_n)",
                     tag, actual, expected);
        end
    endtask

    function automatic logic tb_is_mem(input logic [OPCODE_WIDTH-1:0] op);
        return op == OPER_READ_MEM || op == OPER_READ_INST || op == OPER_WRITE_MEM ||
               op == OPER_PUSH_TO_STACK || op == OPER_POP_FROM_STACK;
    endfunction

    // Expected EXEC-cycle vector, written straight from the operation table.
    function automatic logic [12:0] exp_exec(input logic [OPCODE_WIDTH-1:0] op, input logic fin);
        logic [8:0] s;
        logic       ill;
        ill = 1'b0;
        case (op)
            OPER_READ_REGS:                s = 9'b100000_111;
            OPER_WRITE_REG:                s = 9'b100010_111;
            OPER_ENABLE_ALU_AND_RUN:       s = 9'b000001_111;
            OPER_RESET:                    s = 9'b110000_111;
            OPER_SET_PC, OPER_HALT:        s = IDLE_S;
            OPER_READ_MEM, OPER_READ_INST: s = 9'b000000_100;
            OPER_WRITE_MEM:                s = 9'b000000_001;
            OPER_PUSH_TO_STACK:            s = fin ? 9'b101010_001 : 9'b000000_001;
            OPER_POP_FROM_STACK:           s = fin ? 9'b100110_100 : 9'b000000_100;
            default: begin
                s   = IDLE_S;
                ill = 1'b1;
            end
        endcase
        return {1'b0, fin, ill & fin, 1'b0, s};
    endfunction

    // Queue the expectation for the cycle now visible, then set inputs for the next edge.
    task automatic step(input string tag, input logic [12:0] exp, input logic r,
                        input logic v, input logic [OPCODE_WIDTH-1:0] op);
        @(posedge clk);
        #1;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        rst       = r;
        op_valid  = v;
        operation = op;
    endtask

    // Issue one op from IDLE; during EXEC op_valid stays high with OPER_HALT to show it is ignored.
    task automatic applyStimulus(input logic [OPCODE_WIDTH-1:0] op, input string name);
        int n;
        n = tb_is_mem(op) ? W + 1 : 1;
        step({name, "_idle"}, READY_IDLE, 1'b0, 1'b1, op);
        for (int k = 0; k < n; k++) begin
            step($sformatf("%s_c%0d", name, k), exp_exec(op, k == n - 1),
                 1'b0, 1'b1, OPER_HALT);
        end
    endtask

    initial begin : checker_proc
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                checkOutput(tag_q.pop_front(), act_vec, exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        logic [OPCODE_WIDTH-1:0] all_ones;
        all_ones = '1;

        for (int i = 0; i < 3; i++) begin
            step($sformatf("reset_%0d", i), READY_IDLE, i < 2, 1'b0, '0);
        end

        applyStimulus(OPER_WRITE_REG, "write_reg");
        applyStimulus(OPER_PUSH_TO_STACK, "push");
        applyStimulus(OPER_POP_FROM_STACK, "pop");
        applyStimulus(OPER_READ_REGS, "read_regs");
        applyStimulus(OPER_ENABLE_ALU_AND_RUN, "alu");
        applyStimulus(OPER_RESET, "rf_reset");
        applyStimulus(OPER_SET_PC, "set_pc");
        applyStimulus(OPER_READ_INST, "read_inst");
        applyStimulus(OPER_WRITE_MEM, "write_mem");

        // READ_MEM aborted by reset during its second active cycle.
        step("rdm_idle", READY_IDLE, 1'b0, 1'b1, OPER_READ_MEM);
        step("rdm_c0", exp_exec(OPER_READ_MEM, 1'b0), 1'b0, 1'b0, '0);
        step("rdm_c1", exp_exec(OPER_READ_MEM, 1'b0), 1'b1, 1'b0, '0);
        applyStimulus(OPER_READ_MEM, "read_mem_after_rst");

        applyStimulus(all_ones, "illegal");
        applyStimulus(OPER_WRITE_REG, "after_illegal");

        applyStimulus(OPER_HALT, "halt");
        for (int i = 0; i < 5; i++) begin
            step($sformatf("halted_%0d", i), HALTED_VEC, i == 4, 1'b1, OPER_READ_REGS);
        end
        applyStimulus(OPER_READ_REGS, "after_halt");

        // Zero-wait instance: the whole push completes in the first EXEC cycle.
        step("w0_pre", READY_IDLE, 1'b0, 1'b0, '0);
        w0_valid     = 1'b1;
        w0_operation = OPER_PUSH_TO_STACK;
        step("w0_accept", READY_IDLE, 1'b0, 1'b0, '0);
        w0_valid     = 1'b0;
        checkOutput("w0_push", w0_vec, {4'b0100, 9'b101010_001});
        step("w0_after", READY_IDLE, 1'b0, 1'b0, '0);
        checkOutput("w0_ready", w0_vec, READY_IDLE);

        step("tail", READY_IDLE, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control sequencer that replaces the single-cycle opcode decoder between the instruction/operation source and the register file, ALU and SRAM. It latches one operation per handshake and drives the register-file, ALU and SRAM control strobes for as many cycles as the operation needs. Memory operations are stretched by a parametrised SRAM wait-state count, and register-file side effects fire exactly once per operation. It adds halt, illegal-opcode reporting and a valid/ready handshake.

## Interface
- OPERATION_CODE_LENGTH, default `operation_code_length`: opcode width.
- SRAM_WAIT_CYCLES, default 1: extra cycles an SRAM access is held, range 0..15.
- WAIT_CNT_WIDTH, default 4: wait counter width; must satisfy 2^WAIT_CNT_WIDTH > SRAM_WAIT_CYCLES.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- operation  in  OPERATION_CODE_LENGTH  opcode, sampled on accept
- op_valid  in  1  operation is valid
- op_ready  out  1  sequencer can accept (high only in IDLE)
- done  out  1  one-cycle pulse in the last active cycle of an operation
- illegal_op  out  1  one-cycle pulse alongside done for an undefined opcode
- halted  out  1  high while in HALTED
- w_RegFile_en_reg_file, w_RegFile_rst, w_RegFile_inc, w_RegFile_dec, w_RegFile_en_write, w_ALU_enable_alu  out  1 each  active-high strobes
- w_SRAM_wr_n, w_SRAM_cs_n, w_SRAM_oe_n  out  1 each  active-low SRAM controls

## Operation
- Idle vector: all active-high strobes 0, cs_n = wr_n = oe_n = 1.
- States: IDLE, EXEC, HALTED.
- IDLE: op_ready = 1. When op_valid is high, latch operation, load wait counter, go to EXEC.
- EXEC, non-memory ops:
  - OPER_READ_REGS: en_reg_file.
  - OPER_WRITE_REG: en_reg_file + en_write.
  - OPER_ENABLE_ALU_AND_RUN: enable_alu.
  - OPER_RESET: en_reg_file + RegFile_rst.
  - OPER_SET_PC: idle vector.
  - All last 1 cycle, with done; then IDLE.
- EXEC, memory ops. Counter loads SRAM_WAIT_CYCLES and decrements each cycle. EXEC lasts SRAM_WAIT_CYCLES+1 cycles, and done is high when the counter = 0.
  - OPER_READ_MEM, OPER_READ_INST: cs_n = 0, oe_n = 0, wr_n = 1 throughout.
  - OPER_WRITE_MEM: cs_n = 0, wr_n = 0, oe_n = 1 throughout.
  - OPER_PUSH_TO_STACK: write SRAM controls throughout. en_reg_file + en_write + inc in the final cycle only.
  - OPER_POP_FROM_STACK: read SRAM controls throughout. en_reg_file + en_write + dec in the final cycle only.
- OPER_HALT: 1 EXEC cycle with idle vector and done, then HALTED.
- HALTED: op_ready = 0, halted = 1, idle vector. Only rst exits.
- Undefined opcode: 1 EXEC cycle with idle vector, done = 1, illegal_op = 1, then IDLE.
- Outputs derive only from state, latched opcode and counter. There is no combinational path from operation or op_valid to any output.

## Timing
- rst high at an edge: next cycle is IDLE, counter 0, latched opcode cleared.
  - Reset values: op_ready = 1, done = 0, illegal_op = 0, halted = 0, all strobes 0, cs_n/wr_n/oe_n = 1.
  - rst overrides any state, including mid-wait and HALTED. No partial inc/dec may fire.
- Accept at edge T → EXEC starts at cycle T+1.
  - Non-memory op: done in T+1, op_ready high in T+2. Issue interval is 2 cycles.
  - Memory op: active cycles T+1 .. T+1+SRAM_WAIT_CYCLES, op_ready high in T+2+SRAM_WAIT_CYCLES.
- SRAM_WAIT_CYCLES = 0: memory ops take 1 cycle, and the inc/dec cycle coincides with the SRAM cycle.
- operation and op_valid are ignored outside IDLE. Opcode changes during EXEC have no effect.
- inc and dec are never high together. RegFile_rst is never high with en_write.

## Structure
- Package control_sequencer_pkg holds:
  - opcode localparams (contents of operation_codes_list.h);
  - state enum;
  - packed control-vector struct (9 strobes);
  - IDLE_VECTOR constant;
  - is_mem_op() function.
- Sub-module control_decode: pure combinational map from opcode + final-cycle flag to control vector + illegal flag.
- control_sequencer keeps the FSM, latch, counter and handshake.

## Test plan
- rst held 3 cycles, then released: every output equals its reset value; op_ready = 1 in the first cycle after release.
- OPER_WRITE_REG accepted at T, SRAM_WAIT_CYCLES = 2: en_reg_file = en_write = 1 and done = 1 only in T+1; op_ready = 1 at T+2.
- OPER_PUSH_TO_STACK, SRAM_WAIT_CYCLES = 2: cs_n = 0, wr_n = 0 during T+1..T+3; inc = en_write = 1 only in T+3 with done; the same sequence with SRAM_WAIT_CYCLES = 0 shows all of it in T+1.
- OPER_READ_MEM accepted, rst asserted in T+2 of 3 active cycles: idle vector from T+3; no done pulse; next op accepted normally.
- OPER_HALT, then op_valid held high with OPER_READ_REGS: halted = 1 and op_ready = 0 indefinitely; rst returns to IDLE.
- Undefined opcode (e.g. all-ones, if unassigned): done = illegal_op = 1 for one cycle with idle vector; following op executes normally.
